// File: rtl/wb_uart_rx_slave.sv
// Wishbone B4 classic slave wrapping an 8N1 UART receiver.
// Received bytes queue in a FIFO; status, control and baud divider are bus-visible.
module wb_uart_rx_slave #(
    parameter logic [15:0] CLK_DIV    = 16'd868,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    input  logic        srx_i,
    output logic        int_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          sync1, sync2, rx_prev;
    logic          en, ie, ovr, fe;
    logic [15:0]   bauddiv;
    state_t        state;
    logic [15:0]   cnt;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          push_pend, fe_pend;
    logic [7:0]    rx_byte;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;

    logic [15:0]   div_eff, half;
    logic          fall, nempty, full;
    logic          req, rd_pop, ctrl_wr, baud_wr, clr, flush;
    logic          do_push, ovr_set;
    logic [1:0]    addr;
    logic [31:0]   rdata;
    logic          unused;

    assign unused  = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_sel_i[3:2], wb_dat_i[31:16]};
    assign div_eff = (bauddiv < 16'd4) ? 16'd4 : bauddiv;
    assign half    = div_eff >> 1;
    assign fall    = rx_prev & ~sync2;
    assign nempty  = (count != '0);
    assign full    = (count == CW'(FIFO_DEPTH));

    assign addr    = wb_adr_i[3:2];
    assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign rd_pop  = req & ~wb_we_i & (addr == 2'd0) & nempty;
    assign ctrl_wr = req & wb_we_i & (addr == 2'd2) & wb_sel_i[0];
    assign baud_wr = req & wb_we_i & (addr == 2'd3);
    assign clr     = ctrl_wr & wb_dat_i[1];
    assign flush   = ctrl_wr & wb_dat_i[3];

    // a pop in the same cycle frees the slot, so a full FIFO still accepts the byte
    assign do_push = push_pend & ~flush & (~full | rd_pop);
    assign ovr_set = push_pend & ~flush & full & ~rd_pop;

    // register read mux, sampled into wb_dat_o at the ack edge
    always_comb begin
        rdata = '0;
        case (addr)
            2'd0: rdata = {24'b0, nempty ? mem[rptr] : 8'h00};
            2'd1: rdata = {21'b0, 7'(count), fe, ovr, full, nempty};
            2'd2: rdata = {29'b0, ie, 1'b0, en};
            default: rdata = {16'b0, bauddiv};
        endcase
    end

    // two-flop synchronizer plus a delayed copy for falling-edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= srx_i;
            sync2   <= sync1;
            rx_prev <= sync2;
        end
    end

    // receive FSM; the finished byte and its stop verdict are registered out
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            push_pend <= 1'b0;
            fe_pend   <= 1'b0;
            rx_byte   <= '0;
        end else begin
            push_pend <= 1'b0;
            fe_pend   <= 1'b0;
            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (fall) state <= START;
                    end
                    START: begin
                        if (cnt >= half - 16'd1) begin
                            cnt    <= '0;
                            bitcnt <= '0;
                            state  <= sync2 ? IDLE : DATA;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    DATA: begin
                        if (cnt >= div_eff - 16'd1) begin
                            cnt    <= '0;
                            shreg  <= {sync2, shreg[7:1]};
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'd7) state <= STOP;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: begin
                        if (cnt >= div_eff - 16'd1) begin
                            cnt       <= '0;
                            state     <= IDLE;
                            push_pend <= sync2;
                            fe_pend   <= ~sync2;
                            rx_byte   <= shreg;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                endcase
            end
        end
    end

    // control, divider and sticky error flags; new errors win over a clear
    always_ff @(posedge clock) begin
        if (reset) begin
            en      <= 1'b1;
            ie      <= 1'b0;
            bauddiv <= CLK_DIV;
            ovr     <= 1'b0;
            fe      <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                en <= wb_dat_i[0];
                ie <= wb_dat_i[2];
            end
            if (baud_wr && wb_sel_i[0]) bauddiv[7:0]  <= wb_dat_i[7:0];
            if (baud_wr && wb_sel_i[1]) bauddiv[15:8] <= wb_dat_i[15:8];
            if (clr) begin
                ovr <= 1'b0;
                fe  <= 1'b0;
            end
            if (ovr_set) ovr <= 1'b1;
            if (fe_pend) fe  <= 1'b1;
        end
    end

    // FIFO pointers and occupancy; flush discards everything including a push
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (rd_pop)  rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(rd_pop);
        end
    end

    // FIFO storage
    always_ff @(posedge clock) begin
        if (do_push) mem[wptr] <= rx_byte;
    end

    // single-cycle ack with registered read data, zero outside the ack
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= req;
            wb_dat_o <= (req && !wb_we_i) ? rdata : 32'h0;
        end
    end

    // registered level interrupt
    always_ff @(posedge clock) begin
        if (reset) int_o <= 1'b0;
        else       int_o <= ie & (nempty | ovr | fe);
    end

endmodule
